// File: rtl/dpram_arb_pkg.sv
// Shared types for the dual-port RAM port arbiter.
// FSM state encoding, requester id and fixed sizing constants.
package dpram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  typedef logic req_id_t;

  localparam int NUM_REQ       = 2;
  localparam int ISSUE_LATENCY = 2;

endpackage

// File: rtl/dpram_port_arbiter_if.sv
// Requester and RAM write/B-port bundle for dpram_port_arbiter.
// master = requesters plus RAM, slave = the arbiter.
interface dpram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);

  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack0;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_doutb;

  modport master (
    output req0, req1,
    output we0, we1,
    output addr0, addr1,
    output wdata0, wdata1,
    input  ack0, ack1,
    input  rdata0, rdata1,
    input  ram_we, ram_waddr, ram_wdata,
    output ram_doutb
  );

  modport slave (
    input  req0, req1,
    input  we0, we1,
    input  addr0, addr1,
    input  wdata0, wdata1,
    output ack0, ack1,
    output rdata0, rdata1,
    output ram_we, ram_waddr, ram_wdata,
    input  ram_doutb
  );

endinterface

// File: rtl/dpram_arb_pick.sv
// Combinational winner selection between the two requesters.
// On a tie the requester named by ptr wins.
import dpram_arb_pkg::*;

module dpram_arb_pick (
  input  logic    req0,
  input  logic    req1,
  input  req_id_t ptr,
  output logic    gnt_valid,
  output req_id_t gnt_id
);

  logic [NUM_REQ-1:0] req_vec;

  assign req_vec = {req1, req0};

  always_comb begin
    gnt_valid = |req_vec;
    gnt_id    = '0;
    unique case (1'b1)
      (req_vec == 2'b11): gnt_id = ptr;
      (req_vec == 2'b10): gnt_id = 1'b1;
      default:            gnt_id = '0;
    endcase
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Two-requester arbiter for a RAM write/B port, read-before-write.
// Define DPRAM_ARB_ROUND_ROBIN_EN for round-robin ties, else fixed priority.
import dpram_arb_pkg::*;

module dpram_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input logic                 clk,
  input logic                 reset_n,
  dpram_port_arbiter_if.slave arb
);

  state_e                state_q, state_d;
  req_id_t               id_q, id_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  req_id_t ptr;
  logic    gnt_valid;
  req_id_t gnt_id;
  logic    in_capture;

  dpram_arb_pick u_pick (
    .req0      (arb.req0),
    .req1      (arb.req1),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

`ifdef DPRAM_ARB_ROUND_ROBIN_EN
  req_id_t ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && gnt_valid)
      ptr_d = ~gnt_id;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d = ST_ISSUE;
          id_d    = gnt_id;
          we_d    = gnt_id ? arb.we1 : arb.we0;
          addr_d  = gnt_id ? arb.addr1 : arb.addr0;
          wdata_d = gnt_id ? arb.wdata1 : arb.wdata0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
        if (id_q)
          rdata1_d = arb.ram_doutb;
        else
          rdata0_d = arb.ram_doutb;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      id_q     <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // ack and rdata bypass the register so data is valid in the ack cycle;
  // a reset asserted in CAPTURE suppresses the ack immediately.
  assign in_capture = reset_n && (state_q == ST_CAPTURE);

  assign arb.ack0 = in_capture && !id_q;
  assign arb.ack1 = in_capture && id_q;

  assign arb.rdata0 = arb.ack0 ? arb.ram_doutb : rdata0_q;
  assign arb.rdata1 = arb.ack1 ? arb.ram_doutb : rdata1_q;

  assign arb.ram_we    = (state_q == ST_ISSUE) && we_q;
  assign arb.ram_waddr = addr_q;
  assign arb.ram_wdata = wdata_q;

  a_ack_excl: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(arb.ack0 && arb.ack1)
  );

  a_we_pulse: assert property (
    @(posedge clk) disable iff (!reset_n)
    arb.ram_we |=> !arb.ram_we
  );

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural B-port RAM.
// Tie-order expectations follow DPRAM_ARB_ROUND_ROBIN_EN.
module tb_dpram_port_arbiter;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  dpram_port_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

  dpram_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .arb     (bus)
  );

  logic [7:0] mem [0:65535];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    bus.ram_doutb <= mem[bus.ram_waddr];
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input logic v, input logic w,
                       input logic [15:0] a, input logic [7:0] d);
    if (r) begin
      bus.req1 = v; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = v; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  task automatic do_access(input bit r, input logic w,
                           input logic [15:0] a, input logic [7:0] d,
                           input logic [7:0] exp_rd, input string tag);
    int n;
    n = 0;
    drive(r, 1'b1, w, a, d);
    do begin
      tick();
      n++;
    end while ((r ? bus.ack1 : bus.ack0) !== 1'b1 && n < 8);
    chk({tag, "_lat"}, n, 2);
    chk({tag, "_rd"}, r ? bus.rdata1 : bus.rdata0, exp_rd);
    drive(r, 1'b0, 1'b0, a, d);
    tick();
    chk({tag, "_ackoff"}, r ? bus.ack1 : bus.ack0, 1'b0);
  endtask

  initial begin
    int n;
    bit exp_id;
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    tick();
    tick();
    chk("rst_ack0", bus.ack0, 1'b0);
    chk("rst_ack1", bus.ack1, 1'b0);
    chk("rst_we", bus.ram_we, 1'b0);
    chk("rst_waddr", bus.ram_waddr, 16'h0);
    chk("rst_wdata", bus.ram_wdata, 8'h0);
    chk("rst_rdata0", bus.rdata0, 8'h0);
    chk("rst_rdata1", bus.rdata1, 8'h0);
    reset_n = 1'b1;
    tick();

    // single write
    drive(1'b0, 1'b1, 1'b1, 16'h0010, 8'hA5);
    tick();
    chk("wr_we", bus.ram_we, 1'b1);
    chk("wr_waddr", bus.ram_waddr, 16'h0010);
    chk("wr_wdata", bus.ram_wdata, 8'hA5);
    chk("wr_ack_early", bus.ack0, 1'b0);
    tick();
    chk("wr_ack0", bus.ack0, 1'b1);
    chk("wr_ack1", bus.ack1, 1'b0);
    chk("wr_we_off", bus.ram_we, 1'b0);
    chk("wr_rdata0_old", bus.rdata0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 16'h0010, 8'hA5);
    tick();
    chk("wr_ack_off", bus.ack0, 1'b0);

    // read after write on requester 1
    drive(1'b1, 1'b1, 1'b0, 16'h0010, 8'h00);
    tick();
    chk("rd_we", bus.ram_we, 1'b0);
    tick();
    chk("rd_ack1", bus.ack1, 1'b1);
    chk("rd_rdata1", bus.rdata1, 8'hA5);
    drive(1'b1, 1'b0, 1'b0, 16'h0010, 8'h00);
    tick();
    chk("rd_rdata1_hold", bus.rdata1, 8'hA5);
    chk("rd_rdata0_keep", bus.rdata0, 8'h00);

    // read-before-write
    do_access(1'b0, 1'b1, 16'h0020, 8'h11, 8'h00, "rbw_init");
    do_access(1'b0, 1'b1, 16'h0020, 8'h22, 8'h11, "rbw_wr");
    do_access(1'b1, 1'b0, 16'h0020, 8'h00, 8'h22, "rbw_rd");

    // contention: both held for four grants
    drive(1'b0, 1'b1, 1'b0, 16'h0010, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 16'h0020, 8'h00);
    for (int g = 0; g < 4; g++) begin
      n = 0;
      do begin
        tick();
        n++;
        chk("cont_excl", bus.ack0 & bus.ack1, 1'b0);
      end while (bus.ack0 !== 1'b1 && bus.ack1 !== 1'b1 && n < 8);
      chk("cont_gap", n, (g == 0) ? 2 : 3);
`ifdef DPRAM_ARB_ROUND_ROBIN_EN
      exp_id = g[0];
`else
      exp_id = 1'b0;
`endif
      chk("cont_id", bus.ack1, exp_id);
      if (exp_id) chk("cont_rd1", bus.rdata1, 8'h22);
      else        chk("cont_rd0", bus.rdata0, 8'hA5);
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    tick();

    // reset during CAPTURE
    drive(1'b0, 1'b1, 1'b0, 16'h0020, 8'h00);
    tick();
    tick();
    chk("mid_ack_pre", bus.ack0, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_ack_rst", bus.ack0, 1'b0);
    tick();
    chk("mid_ack0", bus.ack0, 1'b0);
    chk("mid_we", bus.ram_we, 1'b0);
    chk("mid_waddr", bus.ram_waddr, 16'h0);
    chk("mid_wdata", bus.ram_wdata, 8'h0);
    chk("mid_rdata0", bus.rdata0, 8'h0);
    chk("mid_rdata1", bus.rdata1, 8'h0);
    reset_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.ack0 !== 1'b1 && n < 8);
    chk("mid_reserve_lat", n, 2);
    chk("mid_reserve_rd", bus.rdata0, 8'h22);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
